sample_buffer_reader: RTL and testbench
=======================================

Name: sample_buffer_reader

Overview:
- Downstream consumer of the 12-bit-write / 48-bit-read sample buffer RAM.
- Reads one 48-bit word per fill, i.e. four packed 12-bit ADC samples. The buffer RAM is single-port-read, bypass mode, one-cycle read latency.
- Serialises each word into 6 bytes on a valid/ready byte stream toward the host link (UART/SPI framer).
- Tracks the read pointer against the writer's word pointer and returns it to the writer for full detection.

Parameters:
- ADDR_W, 5, read-side word address width; buffer depth is 2^ADDR_W words.
- DATA_W, 48, read word width; fixed at 48, 6 bytes per word.

Ports:
- clk  input  1  single clock, drives the RAM read side as well.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  when high, fetch words while the buffer is non-empty; when low, finish the current word then idle.
- clear  input  1  synchronous discard: abort the transfer and set rd_ptr to wr_ptr.
- wr_ptr  input  ADDR_W+1  writer's count of completed words; MSB is the wrap bit.
- rd_ptr  output  ADDR_W+1  words consumed; MSB is the wrap bit.
- ceb  output  1  RAM read-port clock enable.
- oce  output  1  RAM output clock enable; tied 1 (bypass mode).
- adb  output  ADDR_W  RAM read address.
- dout  input  DATA_W  RAM read data, valid the cycle after ceb.
- tx_data  output  8  byte to link.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  link accepts the byte.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE, rd_ptr 0, adb 0, ceb 0, tx_valid 0, tx_data 0, busy 0. oce is constant 1.
- Reset mid-transfer drops tx_valid immediately because reset is asynchronous. The partial word is lost.
- empty = (rd_ptr == wr_ptr). Pointer compare uses the full ADDR_W+1 bits; the wrap bit distinguishes full from empty on the writer side.
- adb = rd_ptr[ADDR_W-1:0], registered and updated together with rd_ptr.
- FSM states: IDLE, RD, CAP, SEND.
- IDLE: if en && !empty, go to RD.
- RD: ceb=1 for exactly one cycle; go to CAP.
- CAP: dout is valid. Latch dout into a 48-bit shift register, rd_ptr += 1 (wraps modulo 2^(ADDR_W+1)), byte index := 0, go to SEND.
  - tx_valid rises in the cycle after CAP.
  - Latency: en with non-empty buffer sampled in IDLE, then first byte valid 3 cycles later.
- SEND: tx_data = shreg[7:0], tx_valid=1.
  - On tx_valid && tx_ready: shift right by 8, index += 1.
  - On acceptance of byte 5 (the 6th byte): if en && !empty (evaluated with the already-incremented rd_ptr), go to RD; else go to IDLE.
  - tx_valid is low from the cycle after the last handshake.
  - Back-to-back throughput: 6 bytes per 8 cycles with tx_ready held high.
- Byte order, LSB first: byte k = word[8k+7:8k]. Sample j of the word occupies word[12j+11:12j].
- tx_data and tx_valid are stable while tx_valid && !tx_ready. The AXI-style rule applies: no retraction, no data change before acceptance.
- en deasserted in SEND has no effect until the word completes. en deasserted in RD or CAP still completes that word.
- clear (any state): next state IDLE, tx_valid 0, ceb 0, rd_ptr := wr_ptr, adb := wr_ptr[ADDR_W-1:0].
  - clear wins over a simultaneous handshake and over reads.
  - The byte handshaked in the clear cycle counts as accepted by the link. No further bytes of that word are sent.
- wr_ptr changes at any time. It is only sampled via the empty check in IDLE and at word end. The writer guarantees monotonic advance.
- rd_ptr advances at CAP, not at word end. The writer may overwrite that slot during SEND because the data is already latched.

Test Plan:
- Single word: wr_ptr 0→1, RAM word 0 = 48'hBA9876543210, tx_ready=1.
  - Required: ceb one pulse with adb=0; bytes 10,32,54,76,98,BA; rd_ptr=1.
  - Required: first tx_valid 3 cycles after en&&!empty; busy low after byte 6.
- Backpressure: same word, tx_ready toggles 1,0,0,1,...
  - Required: each byte is held unchanged while stalled; still exactly 6 handshakes, in order.
- Wrap: preset rd_ptr=wr_ptr=31, writer then sets wr_ptr=34.
  - Required: reads adb 31,0,1; rd_ptr ends 6'd34 (100010b); 18 bytes, each word followed directly by RD with no IDLE cycle.
- en low mid-word: wr_ptr=3, drop en during byte 2 of word 0.
  - Required: word 0 completes (6 bytes), FSM goes to IDLE, rd_ptr=1, no ceb pulse until en returns.
- clear during SEND: clear asserted on byte 3 with wr_ptr=5.
  - Required: tx_valid 0 next cycle, rd_ptr=5, FSM in IDLE; no further bytes; next ceb only when wr_ptr>5.
- Async reset mid-SEND: assert reset between clock edges.
  - Required: tx_valid, ceb, rd_ptr, busy all 0 before the next edge; after release, FSM is in IDLE and adb=0.

Source files
------------

// File: rtl/sample_buffer_reader.sv
// sample_buffer_reader: fetches 48-bit words from the sample RAM and streams them LSB-first as 6 bytes over valid/ready.
module sample_buffer_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clear,
    input  logic [ADDR_W:0]   wr_ptr,
    output logic [ADDR_W:0]   rd_ptr,
    output logic              ceb,
    output logic              oce,
    output logic [ADDR_W-1:0] adb,
    input  logic [DATA_W-1:0] dout,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, RD, CAP, SEND} state_t;

    state_t            r_state;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W-1:0] r_adb;
    logic [DATA_W-1:0] r_shreg;
    logic [2:0]        r_idx;
    logic              r_ceb;
    logic              r_tx_valid;
    logic              r_busy;
    logic              w_more;
    logic              w_hs;
    logic [ADDR_W:0]   w_rd_next;

    // At word end this sees the pointer already advanced in CAP
    assign w_more    = en && (r_rd_ptr != wr_ptr);
    assign w_hs      = r_tx_valid && tx_ready;
    assign w_rd_next = r_rd_ptr + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rd_ptr   <= '0;
            r_adb      <= '0;
            r_shreg    <= '0;
            r_idx      <= '0;
            r_ceb      <= 1'b0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else if (clear) begin
            r_state    <= IDLE;
            r_rd_ptr   <= wr_ptr;
            r_adb      <= wr_ptr[ADDR_W-1:0];
            r_ceb      <= 1'b0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_more) begin
                    r_state <= RD;
                    r_ceb   <= 1'b1;
                    r_busy  <= 1'b1;
                end
                RD: begin
                    r_state <= CAP;
                    r_ceb   <= 1'b0;
                end
                CAP: begin
                    r_state    <= SEND;
                    r_shreg    <= dout;
                    r_rd_ptr   <= w_rd_next;
                    r_adb      <= w_rd_next[ADDR_W-1:0];
                    r_idx      <= '0;
                    r_tx_valid <= 1'b1;
                end
                SEND: if (w_hs) begin
                    r_shreg <= r_shreg >> 8;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == 3'd5) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= w_more ? RD : IDLE;
                        r_ceb      <= w_more;
                        r_busy     <= w_more;
                    end
                end
            endcase
        end
    end

    assign rd_ptr   = r_rd_ptr;
    assign adb      = r_adb;
    assign ceb      = r_ceb;
    assign oce      = 1'b1;
    assign tx_data  = r_shreg[7:0];
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
endmodule

// File: tb/tb_sample_buffer_reader.sv
// tb_sample_buffer_reader: directed and randomized checks of the byte stream against a RAM/scoreboard model.
module tb_sample_buffer_reader;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          clear = 1'b0;
    logic [AW:0]   wr_ptr = '0;
    logic [AW:0]   rd_ptr;
    logic          ceb;
    logic          oce;
    logic [AW-1:0] adb;
    logic [47:0]   dout = '0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          busy;

    logic [47:0]   mem [32];
    logic [7:0]    got_q[$];
    logic [7:0]    exp_q[$];
    logic [AW-1:0] ceb_adb[$];
    int            errors = 0;
    int            checks = 0;

    sample_buffer_reader #(.ADDR_W(AW), .DATA_W(48)) dut (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .wr_ptr(wr_ptr),
        .rd_ptr(rd_ptr), .ceb(ceb), .oce(oce), .adb(adb), .dout(dout),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM read port: data appears one cycle after the enabled read
    always @(posedge clk) if (ceb) dout <= mem[adb];

    always @(posedge clk) begin
        if (!reset) begin
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (ceb) ceb_adb.push_back(adb);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [47:0] w, input int k);
        return w[8*k +: 8];
    endfunction

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic wait_valid(output int n);
        n = 0;
        do begin tick(); n++; end while (!tx_valid && n < 50);
        chk("valid_timeout", 64'(tx_valid), 64'd1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 400) begin tick(); n++; end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic chk_word(input string tag, input int base, input logic [47:0] w);
        for (int k = 0; k < 6; k++)
            chk(tag, (base + k < got_q.size()) ? 64'(got_q[base+k]) : 64'hx, 64'(byte_of(w, k)));
    endtask

    task automatic reposition(input logic [AW:0] p);
        en = 1'b0;
        wr_ptr = p;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        int n, n2, wp;
        logic [47:0] w;
        logic [3:0] pat;
        logic pv, pr;
        logic [7:0] pd;
        logic [AW:0] occ;
        for (int i = 0; i < 32; i++) mem[i] = '0;

        reset = 1'b1;
        tick();
        chk("rst_tx_valid", 64'(tx_valid), 0);
        chk("rst_tx_data", 64'(tx_data), 0);
        chk("rst_rd_ptr", 64'(rd_ptr), 0);
        chk("rst_adb", 64'(adb), 0);
        chk("rst_ceb", 64'(ceb), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("oce_tied", 64'(oce), 1);
        reset = 1'b0;
        tick();

        // single word
        mem[0] = 48'hBA9876543210;
        got_q.delete(); ceb_adb.delete();
        tx_ready = 1'b1; en = 1'b1; wr_ptr = 6'd1;
        wait_valid(n);
        chk("t1_latency", 64'(n), 3);
        wait_idle(n2);
        chk("t1_idle_after_6", 64'(n2), 6);
        chk("t1_tx_valid_low", 64'(tx_valid), 0);
        chk("t1_nbytes", 64'(got_q.size()), 6);
        chk_word("t1_byte", 0, 48'hBA9876543210);
        chk("t1_nceb", 64'(ceb_adb.size()), 1);
        chk("t1_ceb_adb", 64'(ceb_adb[0]), 0);
        chk("t1_rd_ptr", 64'(rd_ptr), 1);

        // backpressure
        mem[1] = 48'hBA9876543210;
        got_q.delete();
        pat = 4'b1001;
        wr_ptr = 6'd2;
        for (int i = 0; i < 100 && !(got_q.size() == 6 && !busy); i++) begin
            tx_ready = pat[i%4];
            pv = tx_valid; pr = tx_ready; pd = tx_data;
            tick();
            if (pv && !pr) begin
                chk("t2_hold_valid", 64'(tx_valid), 1);
                chk("t2_hold_data", 64'(tx_data), 64'(pd));
            end
        end
        tx_ready = 1'b1;
        chk("t2_nbytes", 64'(got_q.size()), 6);
        chk_word("t2_byte", 0, 48'hBA9876543210);
        chk("t2_rd_ptr", 64'(rd_ptr), 2);

        // wrap
        reposition(6'd31);
        chk("t3_rd_preset", 64'(rd_ptr), 31);
        chk("t3_adb_preset", 64'(adb), 31);
        mem[31] = rnd48(); mem[0] = rnd48(); mem[1] = rnd48();
        got_q.delete(); ceb_adb.delete();
        en = 1'b1; wr_ptr = 6'd34;
        wait_valid(n);
        wait_idle(n2);
        chk("t3_back_to_back_cycles", 64'(n + n2), 1 + 8 * 3);
        chk("t3_nceb", 64'(ceb_adb.size()), 3);
        chk("t3_adb0", 64'(ceb_adb[0]), 31);
        chk("t3_adb1", 64'(ceb_adb[1]), 0);
        chk("t3_adb2", 64'(ceb_adb[2]), 1);
        chk("t3_nbytes", 64'(got_q.size()), 18);
        chk_word("t3_w0", 0, mem[31]);
        chk_word("t3_w1", 6, mem[0]);
        chk_word("t3_w2", 12, mem[1]);
        chk("t3_rd_ptr", 64'(rd_ptr), 6'b100010);

        // en low mid-word
        reposition(6'd0);
        mem[0] = rnd48(); mem[1] = rnd48(); mem[2] = rnd48();
        got_q.delete(); ceb_adb.delete();
        en = 1'b1; wr_ptr = 6'd3;
        wait_valid(n);
        tick(); tick();
        en = 1'b0;
        wait_idle(n2);
        chk("t4_nbytes", 64'(got_q.size()), 6);
        chk_word("t4_w0", 0, mem[0]);
        chk("t4_rd_ptr", 64'(rd_ptr), 1);
        repeat (10) tick();
        chk("t4_no_ceb_while_off", 64'(ceb_adb.size()), 1);
        chk("t4_busy_off", 64'(busy), 0);
        en = 1'b1;
        wait_valid(n);
        wait_idle(n2);
        chk("t4_rd_ptr_resume", 64'(rd_ptr), 3);
        chk("t4_nbytes_resume", 64'(got_q.size()), 18);
        chk_word("t4_w1", 6, mem[1]);
        chk_word("t4_w2", 12, mem[2]);

        // clear during SEND
        mem[3] = rnd48(); mem[4] = rnd48();
        got_q.delete(); ceb_adb.delete();
        wr_ptr = 6'd5;
        wait_valid(n);
        tick(); tick(); tick();
        chk("t5_on_byte3", 64'(tx_data), 64'(byte_of(mem[3], 3)));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_tx_valid", 64'(tx_valid), 0);
        chk("t5_rd_ptr", 64'(rd_ptr), 5);
        chk("t5_adb", 64'(adb), 5);
        chk("t5_busy", 64'(busy), 0);
        chk("t5_nbytes", 64'(got_q.size()), 4);
        for (int k = 0; k < 4; k++) chk("t5_byte", 64'(got_q[k]), 64'(byte_of(mem[3], k)));
        repeat (10) tick();
        chk("t5_no_more_bytes", 64'(got_q.size()), 4);
        chk("t5_no_more_ceb", 64'(ceb_adb.size()), 1);
        mem[5] = rnd48();
        wr_ptr = 6'd6;
        wait_valid(n);
        chk("t5_next_adb", 64'(ceb_adb[1]), 5);
        wait_idle(n2);
        chk("t5_rd_ptr_end", 64'(rd_ptr), 6);

        // async reset mid-SEND
        mem[6] = rnd48();
        wr_ptr = 6'd7;
        wait_valid(n);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("t6_tx_valid", 64'(tx_valid), 0);
        chk("t6_ceb", 64'(ceb), 0);
        chk("t6_rd_ptr", 64'(rd_ptr), 0);
        chk("t6_busy", 64'(busy), 0);
        en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("t6_idle_after", 64'(busy), 0);
        chk("t6_adb_after", 64'(adb), 0);

        // randomized traffic against a byte scoreboard
        reposition(6'd0);
        got_q.delete(); exp_q.delete();
        wp = 0;
        for (int c = 0; c < 1500; c++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 7) != 0);
            occ = 6'(wp) - rd_ptr;
            if ($urandom_range(0, 2) == 0 && occ < 6'd30) begin
                w = rnd48();
                mem[wp % 32] = w;
                for (int k = 0; k < 6; k++) exp_q.push_back(byte_of(w, k));
                wp = (wp + 1) % 64;
                wr_ptr = 6'(wp);
            end
            tick();
        end
        en = 1'b1; tx_ready = 1'b1;
        for (int i = 0; i < 800 && (busy || rd_ptr != wr_ptr); i++) tick();
        chk("rnd_drained", 64'(rd_ptr), 64'(wr_ptr));
        chk("rnd_nbytes", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk("rnd_byte", (i < got_q.size()) ? 64'(got_q[i]) : 64'hx, 64'(exp_q[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
